// File: rtl/fir_ss_feeder.sv
// rtl/fir_ss_feeder.sv - reads a sample block from BRAM and streams it to fir's ss port; `FEEDER_PREFILL_EN adds a zero prefill
module fir_ss_feeder #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [31:0]            length,
    output logic                   busy,
    output logic                   done,
    output logic                   ram_EN,
    output logic [pADDR_WIDTH-1:0] ram_A,
    input  logic [pDATA_WIDTH-1:0] ram_Do,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready
);

`ifdef FEEDER_PREFILL_EN
    typedef enum logic [2:0] {S_IDLE, S_PREFILL, S_STREAM, S_DRAIN, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;
`endif

    state_t                 state;
    logic [31:0]            len;
    logic [31:0]            idx;
    logic                   rd_pending;
    logic                   rd_last;
    logic                   skid_valid;
    logic [pDATA_WIDTH-1:0] skid_data;
    logic                   skid_last;

    logic                   pop;
    logic [2:0]             fill_after;
    logic                   issue;
    logic                   pre_push;
    logic                   push;
    logic [pDATA_WIDTH-1:0] push_data;
    logic                   push_last;

    assign pop = ss_tvalid & ss_tready;

    // Occupancy after this edge, counting the read whose data lands now.
    assign fill_after = 3'(ss_tvalid) + 3'(skid_valid) + 3'(rd_pending) - 3'(pop);

    assign issue  = (state == S_STREAM) && (fill_after < 3'd2);
    assign ram_EN = issue;
    assign ram_A  = {idx[pADDR_WIDTH-3:0], 2'b00};

`ifdef FEEDER_PREFILL_EN
    logic [31:0] pre_cnt;
    assign pre_push = (state == S_PREFILL) && (pre_cnt != 32'(Tape_Num)) && (fill_after < 3'd2);
`else
    assign pre_push = 1'b0;
`endif

    assign push      = rd_pending | pre_push;
    assign push_data = rd_pending ? ram_Do : '0;
    assign push_last = rd_pending & rd_last;

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            len        <= '0;
            idx        <= '0;
            rd_pending <= 1'b0;
            rd_last    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
            ss_tvalid  <= 1'b0;
            ss_tdata   <= '0;
            ss_tlast   <= 1'b0;
`ifdef FEEDER_PREFILL_EN
            pre_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;

            // Output register plus one skid entry form the 2-deep buffer.
            if (!ss_tvalid || pop) begin
                if (skid_valid) begin
                    ss_tvalid  <= 1'b1;
                    ss_tdata   <= skid_data;
                    ss_tlast   <= skid_last;
                    skid_valid <= push;
                    if (push) begin
                        skid_data <= push_data;
                        skid_last <= push_last;
                    end
                end else if (push) begin
                    ss_tvalid <= 1'b1;
                    ss_tdata  <= push_data;
                    ss_tlast  <= push_last;
                end else begin
                    ss_tvalid <= 1'b0;
                    ss_tlast  <= 1'b0;
                end
            end else if (push) begin
                skid_valid <= 1'b1;
                skid_data  <= push_data;
                skid_last  <= push_last;
            end

            rd_pending <= issue;
            if (issue) begin
                rd_last <= (idx == len - 32'd1);
                idx     <= idx + 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len  <= length;
                        idx  <= '0;
                        busy <= 1'b1;
`ifdef FEEDER_PREFILL_EN
                        pre_cnt <= '0;
                        state   <= S_PREFILL;
`else
                        if (length == 32'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_STREAM;
                        end
`endif
                    end
                end
`ifdef FEEDER_PREFILL_EN
                S_PREFILL: begin
                    if (pre_push) begin
                        pre_cnt <= pre_cnt + 32'd1;
                    end
                    if ((pre_cnt == 32'(Tape_Num)) && (fill_after == 3'd0)) begin
                        if (len == 32'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_STREAM;
                        end
                    end
                end
`endif
                S_STREAM: begin
                    if (issue && (idx == len - 32'd1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fill_after == 3'd0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ss_feeder.sv
// tb/tb_fir_ss_feeder.sv - table-driven and randomized checks of fir_ss_feeder against a beat-queue model
module tb_fir_ss_feeder;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int TAPES = 11;
`ifdef FEEDER_PREFILL_EN
    localparam int NPRE = TAPES;
    localparam int LAT  = 1;
`else
    localparam int NPRE = 0;
    localparam int LAT  = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   length;
    logic          busy, done, ram_EN;
    logic [AW-1:0] ram_A;
    logic [DW-1:0] ram_Do;
    logic          ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0] ss_tdata;

    always #5 clk = ~clk;

    fir_ss_feeder #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TAPES)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .start(start), .length(length),
        .busy(busy), .done(done), .ram_EN(ram_EN), .ram_A(ram_A), .ram_Do(ram_Do),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready)
    );

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) if (ram_EN) ram_Do <= mem[ram_A[AW-1:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int rmode = 0;
    int ph = 0;
    initial begin
        ss_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       ss_tready = 1'b1;
                1:       ss_tready = (ph % 3 == 0);
                default: ss_tready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    logic [DW:0]   got_q[$];
    int            done_cnt, done_cyc, first_cyc, last_beat_cyc;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(ss_tvalid), 64'd1);
                chk("hold_data", 64'({ss_tlast, ss_tdata}), 64'({prev_last, prev_data}));
            end
            if (ss_tvalid && first_cyc < 0) first_cyc = cyc;
            if (ss_tvalid && ss_tready) begin
                got_q.push_back({ss_tlast, ss_tdata});
                last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = ss_tvalid & !ss_tready;
            prev_data  = ss_tdata;
            prev_last  = ss_tlast;
        end
    end

    typedef struct {
        int len;
        int rmode;
        int restart_at;
        int exp_lat;
        int exp_busy;
    } vec_t;

    function automatic vec_t mk(input int len, input int rm, input int rs);
        vec_t v;
        v.len        = len;
        v.rmode      = rm;
        v.restart_at = rs;
        v.exp_lat    = (len == 0 && NPRE == 0) ? -1 : LAT;
        v.exp_busy   = (len == 0 && NPRE == 0) ? 0 : 1;
        return v;
    endfunction

    task automatic run_block(input vec_t v, input string tag);
        logic [DW:0] exp_q[$];
        logic [DW:0] tmp;
        int start_cyc;
        bit timed_out;
        for (int i = 0; i < NPRE; i++) exp_q.push_back('0);
        for (int i = 0; i < v.len; i++) begin
            tmp = {1'(i == v.len - 1), mem[i]};
            exp_q.push_back(tmp);
        end
        got_q.delete();
        done_cnt  = 0;
        first_cyc = -1;
        rmode     = v.rmode;
        @(posedge clk); #1;
        start     = 1'b1;
        length    = 32'(v.len);
        start_cyc = cyc;
        timed_out = 1'b1;
        for (int k = 1; k < 800; k++) begin
            @(posedge clk); #1;
            start = (k == v.restart_at);
            if (start) length = 32'(v.len + 5);
            @(negedge clk);
            if (k == 1) chk({tag, "_busy"}, 64'(busy), 64'(v.exp_busy));
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
        chk({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        if (v.exp_lat < 0) chk({tag, "_novalid"}, 64'(first_cyc), 64'(-1));
        else chk({tag, "_latency"}, 64'(first_cyc - start_cyc - 1), 64'(v.exp_lat));
        if (exp_q.size() > 0) chk({tag, "_done_time"}, 64'(done_cyc), 64'(last_beat_cyc + 1));
        else chk({tag, "_done_time"}, 64'(done_cyc), 64'(start_cyc + 1));
        @(negedge clk);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    vec_t tbl[7];
    bit   to;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 1);
        rst_n  = 1'b0;
        start  = 1'b0;
        length = '0;
        done_cnt = 0;
        first_cyc = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ram_en", 64'(ram_EN), 64'd0);
        chk("rst_ram_a", 64'(ram_A), 64'd0);
        chk("rst_tvalid", 64'(ss_tvalid), 64'd0);
        chk("rst_tdata", 64'(ss_tdata), 64'd0);
        chk("rst_tlast", 64'(ss_tlast), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        tbl[0] = mk(4, 0, 0);
        tbl[1] = mk(4, 1, 0);
        tbl[2] = mk(0, 0, 0);
        tbl[3] = mk(6, 0, 3);
        tbl[4] = mk(9, 1, 5);
        tbl[5] = mk(1, 0, 0);
        tbl[6] = mk(3, 2, 0);
        for (int t = 0; t < 7; t++) run_block(tbl[t], $sformatf("vec%0d", t));

        // Reset in the middle of an 8-sample block.
        rmode = 0;
        got_q.delete();
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        length = 32'd8;
        @(posedge clk); #1;
        start = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (got_q.size() >= 2 + NPRE) begin
                to = 1'b0;
                break;
            end
        end
        chk("rst_mid_reach", 64'(to), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_tvalid", 64'(ss_tvalid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_mid_nodone", 64'(done_cnt), 64'd0);
        run_block(mk(5, 0, 0), "after_rst");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            run_block(mk($urandom_range(1, 20), 2, 0), $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
